kernel_loader: RTL and testbench

Write-side initiator for the depthwise kernel register file. On a `start` pulse it reads `CHANNELS*9` signed weights from a synchronous-read weight memory, beginning at a per-layer base address. It replays them as an in-order write stream (`wr_en`/`wr_addr`/`wr_data`) into the kernel register bank, then pulses `done`. It sits between the weight BRAM and the kernel register bank, under control of the layer sequencer.

---
 rtl/kernel_loader.sv | 112 +++++++++++
 tb/tb_kernel_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_loader.sv
// Streams CHANNELS*9 weights from a synchronous-read weight memory into the
// depthwise kernel register bank as an in-order write sequence, then pulses done.
module kernel_loader #(
  parameter  int DATA_W   = 8,
  parameter  int CHANNELS = 32,
  parameter  int MEM_AW   = 16,
  parameter  int RD_LAT   = 1,
  localparam int TOTAL    = CHANNELS * 9,
  localparam int IDX_W    = $clog2(TOTAL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [MEM_AW-1:0]        base_addr,
  input  logic                     pause,
  output logic                     mem_rd_en,
  output logic [MEM_AW-1:0]        mem_rd_addr,
  input  logic signed [DATA_W-1:0] mem_rd_data,
  output logic                     wr_en,
  output logic [IDX_W-1:0]         wr_addr,
  output logic signed [DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic                     done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q;
  logic [MEM_AW-1:0]   base_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic                busy_q;
  logic                done_q;
  logic [RD_LAT-1:0]   vld_q;
  logic [IDX_W-1:0]    idx_q [RD_LAT];
  logic                issue;
  logic                last_wr;

  // pause gates the read strobe in the same cycle, so issue is not registered
  assign issue   = (state_q == READ) && !pause;
  assign last_wr = vld_q[RD_LAT-1] && (idx_q[RD_LAT-1] == LAST_IDX);

  assign mem_rd_en   = issue;
  assign mem_rd_addr = base_q + MEM_AW'(rd_idx_q);
  assign wr_en       = vld_q[RD_LAT-1];
  assign wr_addr     = idx_q[RD_LAT-1];
  assign wr_data     = mem_rd_data;
  assign busy        = busy_q;
  assign done        = done_q;

  // Index tag travels alongside each read so the write lands on the right slot
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= issue;
      idx_q[0] <= rd_idx_q;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      rd_idx_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            rd_idx_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= READ;
          end
        end
        READ: begin
          if (!pause) begin
            rd_idx_q <= rd_idx_q + 1'b1;
            if (rd_idx_q == LAST_IDX) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (last_wr) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_loader.sv
// Bench for kernel_loader: two instances (read latency 1 and 3) share stimulus and
// are compared cycle by cycle against a schedule derived from the load rules.
module tb_kernel_loader;
  localparam int CH    = 2;
  localparam int TOTAL = CH * 9;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int IW    = $clog2(TOTAL);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          pause;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] seed = '0;

  logic                 rd_en   [2];
  logic [AW-1:0]        rd_addr [2];
  logic signed [DW-1:0] rd_data [2];
  logic                 wr_en   [2];
  logic [IW-1:0]        wr_addr [2];
  logic signed [DW-1:0] wr_data [2];
  logic                 busy    [2];
  logic                 done    [2];

  int total = 0;
  int bad   = 0;

  kernel_loader #(.DATA_W(DW), .CHANNELS(CH), .MEM_AW(AW), .RD_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .pause(pause),
    .mem_rd_en(rd_en[0]), .mem_rd_addr(rd_addr[0]), .mem_rd_data(rd_data[0]),
    .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .busy(busy[0]), .done(done[0])
  );

  kernel_loader #(.DATA_W(DW), .CHANNELS(CH), .MEM_AW(AW), .RD_LAT(3)) u_lat3 (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .pause(pause),
    .mem_rd_en(rd_en[1]), .mem_rd_addr(rd_addr[1]), .mem_rd_data(rd_data[1]),
    .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .busy(busy[1]), .done(done[1])
  );

  // Weight content: with seed 0 and base 0x0100, word k holds k-9
  function automatic logic signed [DW-1:0] mem_val(input logic [AW-1:0] a);
    logic [AW-1:0] v;
    v = a - 16'h0109 + seed;
    return v[DW-1:0];
  endfunction

  // Memory models: data is X unless a read was issued the right number of cycles earlier
  logic signed [DW-1:0] m1_q;
  logic signed [DW-1:0] m3_q [3];
  always @(posedge clk) begin
    m1_q    <= rd_en[0] ? mem_val(rd_addr[0]) : {DW{1'bx}};
    m3_q[0] <= rd_en[1] ? mem_val(rd_addr[1]) : {DW{1'bx}};
    m3_q[1] <= m3_q[0];
    m3_q[2] <= m3_q[1];
  end
  assign rd_data[0] = m1_q;
  assign rd_data[1] = m3_q[2];

  task automatic apply_reset;
    reset     = 1'b1;
    start     = 1'b0;
    pause     = 1'b0;
    base_addr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Drives one load starting at relative cycle 0 and checks every cycle.
  // p_lo/p_hi: pause window (-1 = none); rst_c: reset cycle (-1 = none);
  // ign: extra starts at cycle 5 and at the latency-1 done cycle; only: dut to check (-1 = both).
  task automatic run_load(input logic [AW-1:0] b, input int p_lo, input int p_hi,
                          input int rst_c, input bit ign, input int only, input int tail);
    int rc [TOTAL];
    int dn [2];
    int c;
    int last;
    int lat;
    logic e_rd, e_wr, e_busy, e_done;
    logic [AW-1:0] e_ra;
    logic [IW-1:0] e_wa;
    logic signed [DW-1:0] e_wd;
    c = 1;
    for (int k = 0; k < TOTAL; k++) begin
      while (p_lo >= 0 && c >= p_lo && c <= p_hi) c++;
      rc[k] = c;
      c++;
    end
    dn[0] = rc[TOTAL-1] + 1 + 1;
    dn[1] = rc[TOTAL-1] + 3 + 1;
    last  = (only >= 0) ? dn[only] + tail : dn[1] + tail;
    if (rst_c >= 0) last = rst_c + tail;
    for (int t = 0; t <= last; t++) begin
      start     = (t == 0) || (ign && (t == 5 || t == dn[0]));
      base_addr = (t == 0) ? b : ~b;
      pause     = (p_lo >= 0 && t >= p_lo && t <= p_hi);
      reset     = (t == rst_c);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        if (only < 0 || only == l) begin
          lat    = (l == 0) ? 1 : 3;
          e_rd   = 1'b0;
          e_wr   = 1'b0;
          e_busy = 1'b0;
          e_done = 1'b0;
          e_ra   = '0;
          e_wa   = '0;
          e_wd   = '0;
          if (!(rst_c >= 0 && t > rst_c)) begin
            for (int k = 0; k < TOTAL; k++) begin
              if (rc[k] == t) begin
                e_rd = 1'b1;
                e_ra = b + AW'(k);
              end
              if (rc[k] + lat == t) begin
                e_wr = 1'b1;
                e_wa = IW'(k);
                e_wd = mem_val(b + AW'(k));
              end
            end
            e_busy = (t >= 1 && t < dn[l]);
            e_done = (t == dn[l]);
          end
          total++;
          if (rd_en[l] !== e_rd) begin
            bad++;
            $display("FAIL rd_en lat%0d cyc%0d: got %b want %b", lat, t, rd_en[l], e_rd);
          end
          if (e_rd) begin
            total++;
            if (rd_addr[l] !== e_ra) begin
              bad++;
              $display("FAIL rd_addr lat%0d cyc%0d: got %h want %h", lat, t, rd_addr[l], e_ra);
            end
          end
          total++;
          if (wr_en[l] !== e_wr) begin
            bad++;
            $display("FAIL wr_en lat%0d cyc%0d: got %b want %b", lat, t, wr_en[l], e_wr);
          end
          if (e_wr) begin
            total++;
            if (wr_addr[l] !== e_wa || wr_data[l] !== e_wd) begin
              bad++;
              $display("FAIL wr_beat lat%0d cyc%0d: got addr %0d data %0d want addr %0d data %0d",
                       lat, t, wr_addr[l], wr_data[l], e_wa, e_wd);
            end
          end
          total++;
          if (busy[l] !== e_busy || done[l] !== e_done) begin
            bad++;
            $display("FAIL busy_done lat%0d cyc%0d: got %b/%b want %b/%b",
                     lat, t, busy[l], done[l], e_busy, e_done);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    pause = 1'b0;
    reset = 1'b0;
    $display("load base=%h pause=%0d..%0d rst=%0d ign=%0d only=%0d cycles=%0d bad=%0d",
             b, p_lo, p_hi, rst_c, ign, only, last + 1, bad);
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    start     = 1'b1;
    pause     = 1'b0;
    base_addr = 16'h1234;
    for (int n = 0; n < 2; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        reset = 1'b0;
        start = 1'b0;
      end
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
        total++;
        if (rd_en[l] !== 1'b0 || rd_addr[l] !== '0 || wr_en[l] !== 1'b0 ||
            wr_addr[l] !== '0 || busy[l] !== 1'b0 || done[l] !== 1'b0) begin
          bad++;
          $display("FAIL reset_state dut%0d step%0d: got rd=%b ra=%h wr=%b wa=%0d busy=%b done=%b want all 0",
                   l, n, rd_en[l], rd_addr[l], wr_en[l], wr_addr[l], busy[l], done[l]);
        end
      end
    end
    @(posedge clk);
    #1;
    $display("reset state checked bad=%0d", bad);
  endtask

  task automatic test_basic;
    apply_reset();
    seed = '0;
    run_load(16'h0100, -1, -1, -1, 1'b0, -1, 3);
  endtask

  task automatic test_pause;
    apply_reset();
    seed = AW'($urandom);
    run_load(16'h0100, 5, 7, -1, 1'b0, -1, 3);
  endtask

  task automatic test_wrap;
    apply_reset();
    seed = AW'($urandom);
    run_load(16'hFFF8, -1, -1, -1, 1'b0, -1, 3);
  endtask

  task automatic test_reset_mid;
    apply_reset();
    seed = AW'($urandom);
    run_load(16'h0200, -1, -1, 8, 1'b0, -1, 6);
    run_load(16'h0300, -1, -1, -1, 1'b0, -1, 2);
  endtask

  task automatic test_ignored_start;
    apply_reset();
    seed = AW'($urandom);
    run_load(16'h0400, -1, -1, -1, 1'b1, -1, 8);
  endtask

  task automatic test_back_to_back;
    for (int d = 0; d < 2; d++) begin
      apply_reset();
      seed = AW'($urandom);
      run_load(AW'($urandom), -1, -1, -1, 1'b0, d, 0);
      run_load(AW'($urandom), -1, -1, -1, 1'b0, d, 3);
    end
  endtask

  task automatic test_random;
    int lo;
    for (int i = 0; i < 4; i++) begin
      apply_reset();
      seed = AW'($urandom);
      lo   = int'($urandom_range(1, 16));
      run_load(AW'($urandom), lo, lo + int'($urandom_range(0, 5)), -1, 1'b0, -1, 2);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    pause     = 1'b0;
    base_addr = '0;
    test_reset();
    test_basic();
    test_pause();
    test_wrap();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
